// File: rtl/wu_fetch.sv
// WU instruction fetch sequencer: issues one read per unstalled cycle over
// num_inst addresses starting at start_addr, repeated num_passes times.
module wu_fetch #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = ADDR_W + 1,
  parameter int unsigned PASS_W = 8
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              mcntl__wuf__start,
  input  logic              mcntl__wuf__abort,
  input  logic [ADDR_W-1:0] mcntl__wuf__start_addr,
  input  logic [CNT_W-1:0]  mcntl__wuf__num_inst,
  input  logic [PASS_W-1:0] mcntl__wuf__num_passes,
  input  logic              wum__wuf__stall,
  output logic              wuf__wum__read,
  output logic [ADDR_W-1:0] wuf__wum__addr,
  output logic              wuf__mcntl__busy,
  output logic              wuf__mcntl__done
);

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]    ninst_q, ninst_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic                read_q, read_d;
  logic                issue;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    start_d = start_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    ninst_d = ninst_q;
    pass_d  = pass_q;
    issue   = (state_q == StFetch) && !wum__wuf__stall;
    read_d  = 1'b0;

    if (mcntl__wuf__abort) begin
      state_d = StIdle;
    end else begin
      read_d = issue;
      if (issue) begin
        addr_d = pc_q;
      end
      unique case (state_q)
        StIdle: begin
          if (mcntl__wuf__start) begin
            start_d = mcntl__wuf__start_addr;
            ninst_d = mcntl__wuf__num_inst;
            pass_d  = (mcntl__wuf__num_passes == '0) ? PASS_W'(1) : mcntl__wuf__num_passes;
            pc_d    = mcntl__wuf__start_addr;
            rem_d   = mcntl__wuf__num_inst;
            state_d = (mcntl__wuf__num_inst == '0) ? StDone : StFetch;
          end
        end
        StFetch: begin
          if (issue) begin
            pc_d  = pc_q + 1'b1;
            rem_d = rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) begin
              // Next pass reloads without a bubble cycle.
              if (pass_q > PASS_W'(1)) begin
                pc_d   = start_q;
                rem_d  = ninst_q;
                pass_d = pass_q - 1'b1;
              end else begin
                state_d = StDone;
              end
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q <= StIdle;
      pc_q    <= '0;
      start_q <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      ninst_q <= '0;
      pass_q  <= '0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      ninst_q <= ninst_d;
      pass_q  <= pass_d;
      read_q  <= read_d;
    end
  end

  assign wuf__wum__read   = read_q;
  assign wuf__wum__addr   = addr_q;
  assign wuf__mcntl__busy = (state_q != StIdle);
  assign wuf__mcntl__done = (state_q == StDone);

endmodule

// File: tb/tb_wu_fetch.sv
// Bench for wu_fetch: directed scenarios plus random traffic against a
// queue-based model of the expected read address stream.
module tb_wu_fetch;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned CNT_W  = 13;
  localparam int unsigned PASS_W = 8;

  logic              clk = 1'b0;
  logic              reset_poweron;
  logic              start, abort, stall;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0]  num_inst;
  logic [PASS_W-1:0] num_passes;
  logic              read, busy, done;
  logic [ADDR_W-1:0] addr;

  always #5 clk = ~clk;

  wu_fetch #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W),
    .PASS_W(PASS_W)
  ) dut (
    .clk                   (clk),
    .reset_poweron         (reset_poweron),
    .mcntl__wuf__start     (start),
    .mcntl__wuf__abort     (abort),
    .mcntl__wuf__start_addr(start_addr),
    .mcntl__wuf__num_inst  (num_inst),
    .mcntl__wuf__num_passes(num_passes),
    .wum__wuf__stall       (stall),
    .wuf__wum__read        (read),
    .wuf__wum__addr        (addr),
    .wuf__mcntl__busy      (busy),
    .wuf__mcntl__done      (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pending addresses of the current run, plus run/finishing flags.
  int unsigned       exp_q[$];
  bit                m_run, m_fin;
  logic              m_read, m_busy, m_done;
  logic [ADDR_W-1:0] m_addr;

  int unsigned seen[$];
  int          done_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge();
    int np;
    if (reset_poweron) begin
      exp_q.delete();
      m_run  = 1'b0;
      m_fin  = 1'b0;
      m_read = 1'b0;
      m_addr = '0;
    end else if (abort) begin
      exp_q.delete();
      m_run  = 1'b0;
      m_fin  = 1'b0;
      m_read = 1'b0;
    end else if (m_fin) begin
      m_fin  = 1'b0;
      m_read = 1'b0;
    end else if (m_run) begin
      m_read = !stall;
      if (!stall) begin
        m_addr = ADDR_W'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_run = 1'b0;
          m_fin = 1'b1;
        end
      end
    end else begin
      m_read = 1'b0;
      if (start) begin
        np = (num_passes == 0) ? 1 : int'(num_passes);
        for (int p = 0; p < np; p++)
          for (int i = 0; i < int'(num_inst); i++)
            exp_q.push_back((int'(start_addr) + i) % (1 << ADDR_W));
        if (exp_q.size() == 0) m_fin = 1'b1;
        else m_run = 1'b1;
      end
    end
    m_busy = m_run | m_fin;
    m_done = m_fin;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("read", 32'(read), 32'(m_read));
    check_eq("addr", 32'(addr), 32'(m_addr));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("done", 32'(done), 32'(m_done));
    if (read) seen.push_back(32'(addr));
    if (done) done_cnt++;
  endtask

  task automatic check_seen(input string tag, input int unsigned e[$]);
    check_eq({tag, "_count"}, 32'(seen.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < seen.size(); i++)
      check_eq({tag, "_addr"}, seen[i], e[i]);
  endtask

  // One run: start pulse, then per-cycle stall mask, optional abort / restart cycle.
  task automatic run_case(input logic [ADDR_W-1:0] sa, input logic [CNT_W-1:0] ni,
                          input logic [PASS_W-1:0] np, input logic [31:0] stall_mask,
                          input int abort_at, input int restart_at);
    int c;
    start_addr = sa;
    num_inst   = ni;
    num_passes = np;
    start      = 1'b1;
    stall      = 1'b0;
    seen.delete();
    done_cnt = 0;
    tick();
    start = 1'b0;
    for (c = 0; c < 80; c++) begin
      stall = (c < 32) ? stall_mask[c] : 1'b0;
      abort = (c == abort_at);
      if (c == restart_at) begin
        start      = 1'b1;
        start_addr = ~sa;
        num_inst   = 1;
        num_passes = 1;
      end
      tick();
      start = 1'b0;
      abort = 1'b0;
      if (!busy) break;
    end
    stall = 1'b0;
    if (c == 80) check_eq("run_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned e[$];
    reset_poweron = 1'b1;
    start = 1'b0; abort = 1'b0; stall = 1'b0;
    start_addr = '0; num_inst = '0; num_passes = '0;
    m_run = 1'b0; m_fin = 1'b0;
    m_read = 1'b0; m_addr = '0; m_busy = 1'b0; m_done = 1'b0;
    tick();
    tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_addr", 32'(addr), 32'd0);
    reset_poweron = 1'b0;
    tick();

    run_case(12'h010, 4, 1, 32'h0, -1, -1);
    e = {32'h010, 32'h011, 32'h012, 32'h013};
    check_seen("basic", e);
    check_eq("basic_done", 32'(done_cnt), 32'd1);

    run_case(12'hFFE, 4, 1, 32'h0, -1, -1);
    e = {32'hFFE, 32'hFFF, 32'h000, 32'h001};
    check_seen("wrap", e);

    run_case(12'h020, 3, 2, 32'h0, -1, -1);
    e = {32'h020, 32'h021, 32'h022, 32'h020, 32'h021, 32'h022};
    check_seen("passes", e);
    check_eq("passes_done", 32'(done_cnt), 32'd1);

    run_case(12'h100, 6, 1, 32'hC, -1, -1);
    e = {32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105};
    check_seen("stall", e);

    run_case(12'h040, 0, 1, 32'h0, -1, -1);
    check_eq("zero_reads", 32'(seen.size()), 32'd0);
    check_eq("zero_done", 32'(done_cnt), 32'd1);

    run_case(12'h200, 5, 1, 32'h0, -1, 1);
    e = {32'h200, 32'h201, 32'h202, 32'h203, 32'h204};
    check_seen("restart_ignored", e);

    run_case(12'h300, 8, 0, 32'h0, 3, -1);
    e = {32'h300, 32'h301, 32'h302};
    check_seen("abort", e);
    check_eq("abort_done", 32'(done_cnt), 32'd0);

    // Reset during FETCH, then a fresh run.
    start_addr = 12'h400; num_inst = 8; num_passes = 1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset_poweron = 1'b1;
    tick();
    reset_poweron = 1'b0;
    check_eq("rst_run_read", 32'(read), 32'd0);
    check_eq("rst_run_addr", 32'(addr), 32'd0);
    check_eq("rst_run_busy", 32'(busy), 32'd0);
    tick();
    run_case(12'h7F0, 2, 3, 32'h5, -1, -1);
    e = {32'h7F0, 32'h7F1, 32'h7F0, 32'h7F1, 32'h7F0, 32'h7F1};
    check_seen("post_reset", e);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 3) == 0);
      start_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'(12'hFFC + $urandom_range(0, 3))
                                                : ADDR_W'($urandom);
      num_inst   = CNT_W'($urandom_range(0, 7));
      num_passes = PASS_W'($urandom_range(0, 3));
      stall      = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 60) == 0);
      reset_poweron = ($urandom_range(0, 200) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; stall = 1'b0; reset_poweron = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
